// File: rtl/wbu_arb_pkg.sv
// Shared definitions for the GPR writeback arbiter: widths, source encoding
// and the write-request record carried through the skid buffers.
package wbu_arb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int GPRS_WIDTH = 5;

    localparam logic WB_SRC_EXU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

    typedef struct packed {
        logic                  wr_en;
        logic [GPRS_WIDTH-1:0] wr_id;
        logic [DATA_WIDTH-1:0] wr_data;
    } wb_req_t;

    // x0 is hardwired to zero, so a write to it retires without a strobe.
    function automatic logic wb_strobe(input wb_req_t req);
        return req.wr_en && (req.wr_id != '0);
    endfunction

endpackage

// File: rtl/wbu_skid.sv
// Single-entry request buffer. Ready depends only on registered occupancy
// and the pop from the arbiter, so there is no valid-to-ready path.
module wbu_skid
    import wbu_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    in_valid,
    output logic    in_ready,
    input  wb_req_t in_req,
    output logic    out_vld,
    output wb_req_t out_req,
    input  logic    pop
);

    // A popped entry frees the slot in the same cycle, allowing back-to-back refill.
    assign in_ready = !rst && (!out_vld || pop);

    // Occupancy and payload; flush and reset drop the entry outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_vld <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_vld <= 1'b1;
            out_req <= in_req;
        end else if (pop) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/wbu_arb.sv
// Round-robin arbiter for the single GPR write port, shared by the EXU
// result path and the LSU load path, with a registered write port.
module wbu_arb
    import wbu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int GPR_W  = GPRS_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_exu_valid,
    output logic              o_exu_ready,
    input  logic              i_exu_wr_en,
    input  logic [GPR_W-1:0]  i_exu_wr_id,
    input  logic [DATA_W-1:0] i_exu_wr_data,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic              i_lsu_wr_en,
    input  logic [GPR_W-1:0]  i_lsu_wr_id,
    input  logic [DATA_W-1:0] i_lsu_wr_data,
    output logic              o_gpr_wr_en,
    output logic [GPR_W-1:0]  o_gpr_wr_id,
    output logic [DATA_W-1:0] o_gpr_wr_data,
    output logic              o_wb_valid,
    output logic              o_wb_src
);

    wb_req_t exu_in;
    wb_req_t lsu_in;
    wb_req_t exu_buf;
    wb_req_t lsu_buf;
    wb_req_t win_req;
    logic    exu_vld;
    logic    lsu_vld;
    logic    grant_exu;
    logic    grant_lsu;
    logic    rr;

    assign exu_in = '{wr_en: i_exu_wr_en, wr_id: i_exu_wr_id, wr_data: i_exu_wr_data};
    assign lsu_in = '{wr_en: i_lsu_wr_en, wr_id: i_lsu_wr_id, wr_data: i_lsu_wr_data};

    wbu_skid u_exu_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_flush),
        .in_valid (i_exu_valid),
        .in_ready (o_exu_ready),
        .in_req   (exu_in),
        .out_vld  (exu_vld),
        .out_req  (exu_buf),
        .pop      (grant_exu)
    );

    wbu_skid u_lsu_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_flush),
        .in_valid (i_lsu_valid),
        .in_ready (o_lsu_ready),
        .in_req   (lsu_in),
        .out_vld  (lsu_vld),
        .out_req  (lsu_buf),
        .pop      (grant_lsu)
    );

    // Grant from registered buffer state only; rr breaks ties.
    always_comb begin
        grant_exu = exu_vld && (!lsu_vld || (rr == WB_SRC_EXU));
        grant_lsu = lsu_vld && (!exu_vld || (rr == WB_SRC_LSU));
        win_req   = grant_lsu ? lsu_buf : exu_buf;
    end

    // Pointer moves only on a contended grant, handing priority to the loser.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr <= WB_SRC_EXU;
        end else if (!i_flush && exu_vld && lsu_vld) begin
            rr <= ~rr;
        end
    end

    // Registered write port; id/data hold when nothing retires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_valid    <= 1'b0;
            o_wb_src      <= WB_SRC_EXU;
            o_gpr_wr_en   <= 1'b0;
            o_gpr_wr_id   <= '0;
            o_gpr_wr_data <= '0;
        end else if (i_flush || !(grant_exu || grant_lsu)) begin
            o_wb_valid  <= 1'b0;
            o_gpr_wr_en <= 1'b0;
        end else begin
            o_wb_valid    <= 1'b1;
            o_wb_src      <= grant_lsu ? WB_SRC_LSU : WB_SRC_EXU;
            o_gpr_wr_en   <= wb_strobe(win_req);
            o_gpr_wr_id   <= win_req.wr_id;
            o_gpr_wr_data <= win_req.wr_data;
        end
    end

endmodule

// File: tb/tb_wbu_arb.sv
// Directed bench for the GPR writeback arbiter.
module tb_wbu_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        exu_valid, exu_ready, exu_wr_en;
    logic [4:0]  exu_wr_id;
    logic [31:0] exu_wr_data;
    logic        lsu_valid, lsu_ready, lsu_wr_en;
    logic [4:0]  lsu_wr_id;
    logic [31:0] lsu_wr_data;
    logic        gpr_wr_en;
    logic [4:0]  gpr_wr_id;
    logic [31:0] gpr_wr_data;
    logic        wb_valid, wb_src;

    int n_checks = 0;
    int n_fail   = 0;

    wbu_arb dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_exu_valid   (exu_valid),
        .o_exu_ready   (exu_ready),
        .i_exu_wr_en   (exu_wr_en),
        .i_exu_wr_id   (exu_wr_id),
        .i_exu_wr_data (exu_wr_data),
        .i_lsu_valid   (lsu_valid),
        .o_lsu_ready   (lsu_ready),
        .i_lsu_wr_en   (lsu_wr_en),
        .i_lsu_wr_id   (lsu_wr_id),
        .i_lsu_wr_data (lsu_wr_data),
        .o_gpr_wr_en   (gpr_wr_en),
        .o_gpr_wr_id   (gpr_wr_id),
        .o_gpr_wr_data (gpr_wr_data),
        .o_wb_valid    (wb_valid),
        .o_wb_src      (wb_src)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; reports which requests were accepted at that edge.
    task automatic step(output logic acc_e, output logic acc_l);
        #1;
        acc_e = exu_valid && exu_ready;
        acc_l = lsu_valid && lsu_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        flush     = 1'b0;
    endtask

    logic ae, al;
    int   exu_q[$];
    int   lsu_q[$];
    int   exp_q[$];
    int   n_out;
    logic saw_9;

    initial begin
        rst = 1'b1; flush = 1'b0;
        exu_valid = 1'b1; exu_wr_en = 1'b1; exu_wr_id = 5'd3; exu_wr_data = 32'h1111_1111;
        lsu_valid = 1'b1; lsu_wr_en = 1'b1; lsu_wr_id = 5'd4; lsu_wr_data = 32'h2222_2222;

        // Reset held three cycles with both requests pending.
        for (int i = 0; i < 3; i++) begin
            step(ae, al);
            check_eq("rst_exu_ready", exu_ready, 0);
            check_eq("rst_lsu_ready", lsu_ready, 0);
        end
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wr_en", gpr_wr_en, 0);
        check_eq("rst_wr_id", gpr_wr_id, 0);
        check_eq("rst_wr_data", gpr_wr_data, 0);
        check_eq("rst_wb_src", wb_src, 0);
        rst = 1'b0;
        idle();
        #1;
        check_eq("post_rst_exu_ready", exu_ready, 1);
        check_eq("post_rst_lsu_ready", lsu_ready, 1);
        step(ae, al);
        check_eq("post_rst_no_write", wb_valid, 0);
        check_eq("post_rst_no_strobe", gpr_wr_en, 0);

        // EXU alone: accepted at edge N, on the port at N+1.
        exu_valid = 1'b1; exu_wr_en = 1'b1; exu_wr_id = 5'd5; exu_wr_data = 32'hDEAD_BEEF;
        step(ae, al);
        check_eq("exu_accept", ae, 1);
        check_eq("exu_lat_n", wb_valid, 0);
        idle();
        step(ae, al);
        check_eq("exu_valid", wb_valid, 1);
        check_eq("exu_wr_en", gpr_wr_en, 1);
        check_eq("exu_wr_id", gpr_wr_id, 5);
        check_eq("exu_wr_data", gpr_wr_data, 32'hDEAD_BEEF);
        check_eq("exu_src", wb_src, 0);
        step(ae, al);
        check_eq("exu_drop_valid", wb_valid, 0);
        check_eq("exu_drop_en", gpr_wr_en, 0);
        check_eq("exu_hold_id", gpr_wr_id, 5);
        check_eq("exu_hold_data", gpr_wr_data, 32'hDEAD_BEEF);

        // x0 write from the LSU retires without a strobe.
        lsu_valid = 1'b1; lsu_wr_en = 1'b1; lsu_wr_id = 5'd0; lsu_wr_data = 32'h0000_1234;
        step(ae, al);
        idle();
        step(ae, al);
        check_eq("x0_valid", wb_valid, 1);
        check_eq("x0_src", wb_src, 1);
        check_eq("x0_wr_en", gpr_wr_en, 0);
        check_eq("x0_data", gpr_wr_data, 32'h0000_1234);

        // Non-writing instruction still retires.
        exu_valid = 1'b1; exu_wr_en = 1'b0; exu_wr_id = 5'd7; exu_wr_data = 32'h0000_0077;
        step(ae, al);
        idle();
        step(ae, al);
        check_eq("nowr_valid", wb_valid, 1);
        check_eq("nowr_wr_en", gpr_wr_en, 0);
        check_eq("nowr_src", wb_src, 0);
        check_eq("nowr_id", gpr_wr_id, 7);
        step(ae, al);

        // Continuous contention: strict alternation starting with EXU.
        for (int i = 1; i <= 6; i++) begin
            exu_q.push_back(i);
            lsu_q.push_back(i + 10);
        end
        exp_q = '{1, 11, 2, 12, 3, 13, 4, 14, 5, 15, 6, 16};
        n_out = 0;
        exu_wr_en = 1'b1; lsu_wr_en = 1'b1;
        for (int cyc = 0; cyc < 40 && n_out < 12; cyc++) begin
            exu_valid = (exu_q.size() > 0);
            lsu_valid = (lsu_q.size() > 0);
            if (exu_valid) begin
                exu_wr_id   = 5'(exu_q[0]);
                exu_wr_data = 32'hA000_0000 | 32'(exu_q[0]);
            end
            if (lsu_valid) begin
                lsu_wr_id   = 5'(lsu_q[0]);
                lsu_wr_data = 32'hB000_0000 | 32'(lsu_q[0]);
            end
            step(ae, al);
            if (ae) void'(exu_q.pop_front());
            if (al) void'(lsu_q.pop_front());
            if (wb_valid) begin
                check_eq("cont_id", gpr_wr_id, exp_q[n_out]);
                check_eq("cont_src", wb_src, (exp_q[n_out] > 10) ? 1 : 0);
                check_eq("cont_data", gpr_wr_data,
                         ((exp_q[n_out] > 10) ? 32'hB000_0000 : 32'hA000_0000) | 32'(exp_q[n_out]));
                n_out++;
            end else if (n_out > 0) begin
                check_eq("cont_gap", wb_valid, 1);
            end
        end
        check_eq("cont_count", n_out, 12);
        idle();
        step(ae, al);

        // Flush with both buffers full; request shown during flush is dropped.
        exu_valid = 1'b1; exu_wr_id = 5'd20; exu_wr_data = 32'hC000_0020;
        lsu_valid = 1'b1; lsu_wr_id = 5'd21; lsu_wr_data = 32'hC000_0021;
        step(ae, al);
        check_eq("fl_fill_exu", ae, 1);
        check_eq("fl_fill_lsu", al, 1);
        flush = 1'b1;
        exu_valid = 1'b1; exu_wr_id = 5'd9; exu_wr_data = 32'hC000_0009;
        lsu_valid = 1'b0;
        step(ae, al);
        check_eq("fl_wb_valid", wb_valid, 0);
        check_eq("fl_wr_en", gpr_wr_en, 0);
        idle();
        #1;
        check_eq("fl_exu_ready", exu_ready, 1);
        check_eq("fl_lsu_ready", lsu_ready, 1);
        saw_9 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(ae, al);
            if (wb_valid && gpr_wr_id == 5'd9) saw_9 = 1'b1;
            check_eq("fl_empty_valid", wb_valid, 0);
        end
        check_eq("fl_no_leak", saw_9, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
